// File: rtl/nou_aw_pkt_sched_if.sv
// -----------------------------------------------------------------------------
// nou_aw_pkt_sched_if
// Bundle of request, grant and AXI AW/B observation signals between the NoC
// packet write scheduler and its surroundings (requesters, AW master
// controller, AXI channel monitors).
//
// Signals:
//   req, req_hdr_num, req_dat_num   requester side: level request and the
//                                   per-requester header/data flit counts
//   grant, grant_id                 one-hot grant and its index
//   start_aw                        one-cycle start pulse to the AW controller
//   header_flit_num, data_flit_num  flit counts latched at grant
//   axi_awvld/axi_awrdy             observed AW channel handshake
//   axi_bvld/axi_brdy               observed B channel handshake
//   aw_hold                         outstanding limit reached, mask AW valid
//   done                            per-requester packet-issued pulse
//   busy, outst_err                 status
//
// Modports:
//   slave  - the scheduler's view
//   master - the environment's view (requesters, AW controller, bench)
// -----------------------------------------------------------------------------
interface nou_aw_pkt_sched_if #(
   parameter int N_REQ = 4,
   parameter int HDR_W = 4,
   parameter int DAT_W = 8
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*HDR_W-1:0] req_hdr_num;
   logic [N_REQ*DAT_W-1:0] req_dat_num;
   logic [N_REQ-1:0]       grant;
   logic [2:0]             grant_id;
   logic                   start_aw;
   logic [HDR_W-1:0]       header_flit_num;
   logic [DAT_W-1:0]       data_flit_num;
   logic                   axi_awvld;
   logic                   axi_awrdy;
   logic                   axi_bvld;
   logic                   axi_brdy;
   logic                   aw_hold;
   logic [N_REQ-1:0]       done;
   logic                   busy;
   logic                   outst_err;

   modport slave (
      input  req, req_hdr_num, req_dat_num,
      input  axi_awvld, axi_awrdy, axi_bvld, axi_brdy,
      output grant, grant_id, start_aw, header_flit_num, data_flit_num,
      output aw_hold, done, busy, outst_err
   );

   modport master (
      output req, req_hdr_num, req_dat_num,
      output axi_awvld, axi_awrdy, axi_bvld, axi_brdy,
      input  grant, grant_id, start_aw, header_flit_num, data_flit_num,
      input  aw_hold, done, busy, outst_err
   );
endinterface

// File: rtl/nou_aw_pkt_sched.sv
// -----------------------------------------------------------------------------
// nou_aw_pkt_sched
// Schedules NoC packet writes from N_REQ local requesters onto the single AXI
// AW master path. A round-robin arbiter picks one requester, latches its
// header/data flit counts, pulses start_aw to the AW controller and counts AW
// handshakes until the packet's total flit count has been issued, then pulses
// done for that requester and releases the grant. Independently it tracks
// outstanding writes (AW accepted, B not yet seen) and raises aw_hold at
// MAX_OUTST so the AW valid can be masked.
//
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   nou_aw_pkt_sched_if.slave (request, grant, AXI observe, status)
//
// State table:
//   state   | meaning
//   S_IDLE  | no packet owned; arbitrate among req each cycle
//   S_START | grant registered; start_aw high for this one cycle
//   S_XFER  | counting AW handshakes until beat_cnt reaches total
// -----------------------------------------------------------------------------
module nou_aw_pkt_sched #(
   parameter int N_REQ     = 4,
   parameter int HDR_W     = 4,
   parameter int DAT_W     = 8,
   parameter int MAX_OUTST = 8
) (
   input  logic               clk,
   input  logic               rstn,
   nou_aw_pkt_sched_if.slave  bus
);

   localparam int TW = ((HDR_W > DAT_W) ? HDR_W : DAT_W) + 1;
   localparam int OW = $clog2(MAX_OUTST + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_XFER  = 2'd2
   } state_t;

   state_t           state;
   logic [N_REQ-1:0] grant_q;
   logic [2:0]       grant_id_q;
   logic             start_aw_q;
   logic [HDR_W-1:0] hdr_q;
   logic [DAT_W-1:0] dat_q;
   logic [TW-1:0]    total_q;
   logic [TW-1:0]    beat_cnt;
   logic [N_REQ-1:0] done_q;
   logic [2:0]       rr_ptr;
   logic [OW-1:0]    outst_cnt;
   logic             outst_err_q;

   logic aw_hs;
   logic b_hs;

   assign aw_hs = bus.axi_awvld & bus.axi_awrdy;
   assign b_hs  = bus.axi_bvld  & bus.axi_brdy;

   // ---------------------------------------------------------------------
   // Round-robin winner: first set req bit at or above rr_ptr, wrapping.
   // cand walks rr_ptr, rr_ptr+1, ... modulo N_REQ; the inner loop keeps
   // every req index constant so no variable bit-select is needed.
   // ---------------------------------------------------------------------
   logic       win_found;
   logic [2:0] win_id;
   logic [3:0] cand;

   always_comb begin
      win_found = 1'b0;
      win_id    = 3'd0;
      cand      = 4'd0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, rr_ptr} + 4'(i);
         if (cand >= 4'(N_REQ)) begin
            cand = cand - 4'(N_REQ);
         end
         for (int j = 0; j < N_REQ; j++) begin
            if (!win_found && (cand == 4'(j)) && bus.req[j]) begin
               win_found = 1'b1;
               win_id    = 3'(j);
            end
         end
      end
   end

   logic [N_REQ-1:0] win_oh;
   logic [HDR_W-1:0] win_hdr;
   logic [DAT_W-1:0] win_dat;

   always_comb begin
      win_oh  = '0;
      win_hdr = '0;
      win_dat = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (win_id == 3'(j)) begin
            win_oh[j] = 1'b1;
            win_hdr   = bus.req_hdr_num[j*HDR_W +: HDR_W];
            win_dat   = bus.req_dat_num[j*DAT_W +: DAT_W];
         end
      end
   end

   logic [2:0] rr_next;
   assign rr_next = (win_id == 3'(N_REQ - 1)) ? 3'd0 : (win_id + 3'd1);

   // ---------------------------------------------------------------------
   // Packet FSM with registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         grant_q    <= '0;
         grant_id_q <= 3'd0;
         start_aw_q <= 1'b0;
         hdr_q      <= '0;
         dat_q      <= '0;
         total_q    <= '0;
         beat_cnt   <= '0;
         done_q     <= '0;
         rr_ptr     <= 3'd0;
      end else begin
         start_aw_q <= 1'b0;
         done_q     <= '0;
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  grant_q    <= win_oh;
                  grant_id_q <= win_id;
                  hdr_q      <= win_hdr;
                  dat_q      <= win_dat;
                  total_q    <= TW'(win_hdr) + TW'(win_dat);
                  rr_ptr     <= rr_next;
                  start_aw_q <= 1'b1;
                  state      <= S_START;
               end
            end
            S_START: begin
               beat_cnt <= '0;
               state    <= S_XFER;
            end
            S_XFER: begin
               // An empty packet finishes without waiting for any handshake.
               if (total_q == '0) begin
                  done_q  <= grant_q;
                  grant_q <= '0;
                  state   <= S_IDLE;
               end else if (aw_hs) begin
                  beat_cnt <= beat_cnt + TW'(1);
                  if ((beat_cnt + TW'(1)) == total_q) begin
                     done_q  <= grant_q;
                     grant_q <= '0;
                     state   <= S_IDLE;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outstanding-write tracking. Simultaneous AW and B cancel out, so the
   // counter only moves (and can only saturate) when exactly one occurs.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outst_cnt   <= '0;
         outst_err_q <= 1'b0;
      end else begin
         if (aw_hs && !b_hs) begin
            if (outst_cnt == OW'(MAX_OUTST)) begin
               outst_err_q <= 1'b1;
            end else begin
               outst_cnt <= outst_cnt + OW'(1);
            end
         end else if (b_hs && !aw_hs) begin
            if (outst_cnt == '0) begin
               outst_err_q <= 1'b1;
            end else begin
               outst_cnt <= outst_cnt - OW'(1);
            end
         end
      end
   end

   assign bus.grant           = grant_q;
   assign bus.grant_id        = grant_id_q;
   assign bus.start_aw        = start_aw_q;
   assign bus.header_flit_num = hdr_q;
   assign bus.data_flit_num   = dat_q;
   assign bus.done            = done_q;
   assign bus.busy            = (state != S_IDLE);
   assign bus.aw_hold         = (outst_cnt == OW'(MAX_OUTST));
   assign bus.outst_err       = outst_err_q;

endmodule

// File: tb/tb_nou_aw_pkt_sched.sv
// -----------------------------------------------------------------------------
// tb_nou_aw_pkt_sched
// Directed bench for nou_aw_pkt_sched: single packet, round-robin order,
// AW backpressure, outstanding limit, error paths, async reset mid-packet
// and the empty-packet case. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_nou_aw_pkt_sched;
   localparam int N_REQ     = 4;
   localparam int HDR_W     = 4;
   localparam int DAT_W     = 8;
   localparam int MAX_OUTST = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   done_cnt [N_REQ];

   nou_aw_pkt_sched_if #(.N_REQ(N_REQ), .HDR_W(HDR_W), .DAT_W(DAT_W)) bus ();

   nou_aw_pkt_sched #(
      .N_REQ(N_REQ), .HDR_W(HDR_W), .DAT_W(DAT_W), .MAX_OUTST(MAX_OUTST)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pkt(input int r, input int h, input int d);
      bus.req_hdr_num[r*HDR_W +: HDR_W] = HDR_W'(h);
      bus.req_dat_num[r*DAT_W +: DAT_W] = DAT_W'(d);
   endtask

   task automatic set_aw(input logic v);
      bus.axi_awvld = v;
      bus.axi_awrdy = v;
   endtask

   task automatic set_b(input logic v);
      bus.axi_bvld = v;
      bus.axi_brdy = v;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (!bus.start_aw && n < 50) begin
         tick();
         n++;
      end
      check(tag, 32'(bus.start_aw), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (bus.done == '0 && n < 50) begin
         tick();
         n++;
      end
      check(tag, 32'(|bus.done), 32'd1);
   endtask

   task automatic bdrain(input int n);
      set_b(1'b1);
      repeat (n) tick();
      set_b(1'b0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic pat [5];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < N_REQ; i++) done_cnt[i] = 0;
      bus.req         = '0;
      bus.req_hdr_num = '0;
      bus.req_dat_num = '0;
      set_aw(1'b0);
      set_b(1'b0);

      // Reset state
      repeat (2) tick();
      check("rst_grant",     32'(bus.grant), 32'd0);
      check("rst_grant_id",  32'(bus.grant_id), 32'd0);
      check("rst_start_aw",  32'(bus.start_aw), 32'd0);
      check("rst_hdr",       32'(bus.header_flit_num), 32'd0);
      check("rst_dat",       32'(bus.data_flit_num), 32'd0);
      check("rst_done",      32'(bus.done), 32'd0);
      check("rst_busy",      32'(bus.busy), 32'd0);
      check("rst_aw_hold",   32'(bus.aw_hold), 32'd0);
      check("rst_outst_err", 32'(bus.outst_err), 32'd0);
      rstn = 1'b1;
      tick();

      // 1. Single packet: hdr=2, dat=3 -> 5 counted handshakes
      set_pkt(0, 2, 3);
      bus.req = 4'b0001;
      tick();
      check("t1_grant",    32'(bus.grant), 32'h1);
      check("t1_grant_id", 32'(bus.grant_id), 32'd0);
      check("t1_start",    32'(bus.start_aw), 32'd1);
      check("t1_hdr",      32'(bus.header_flit_num), 32'd2);
      check("t1_dat",      32'(bus.data_flit_num), 32'd3);
      check("t1_busy",     32'(bus.busy), 32'd1);
      tick();
      check("t1_start_one_cycle", 32'(bus.start_aw), 32'd0);
      set_aw(1'b1);
      repeat (4) tick();
      check("t1_no_done_after_4", 32'(bus.done), 32'd0);
      tick();
      check("t1_done",       32'(bus.done), 32'h1);
      check("t1_grant_clr",  32'(bus.grant), 32'd0);
      check("t1_busy_low",   32'(bus.busy), 32'd0);
      bus.req = '0;
      set_aw(1'b0);
      tick();
      check("t1_done_pulse", 32'(bus.done), 32'd0);
      check("t1_idle",       32'(bus.busy), 32'd0);
      bdrain(5);
      check("t1_outst_err",  32'(bus.outst_err), 32'd0);

      // 2. Round-robin with all requesters held; hdr=1, dat=1 each
      do_reset();
      for (int r = 0; r < N_REQ; r++) set_pkt(r, 1, 1);
      bus.req = 4'b1111;
      set_aw(1'b1);
      set_b(1'b1);
      for (int p = 0; p < 5; p++) begin
         int exp_id;
         exp_id = p % N_REQ;
         wait_start($sformatf("t2_start_%0d", p));
         check($sformatf("t2_grant_id_%0d", p), 32'(bus.grant_id), 32'(exp_id));
         check($sformatf("t2_grant_%0d", p),    32'(bus.grant), 32'(1) << exp_id);
         wait_done($sformatf("t2_done_seen_%0d", p));
         check($sformatf("t2_done_%0d", p),     32'(bus.done), 32'(1) << exp_id);
         for (int r = 0; r < N_REQ; r++) if (bus.done[r]) done_cnt[r]++;
         if (p == 4) bus.req = '0;
      end
      set_aw(1'b0);
      set_b(1'b0);
      check("t2_done_cnt_0", 32'(done_cnt[0]), 32'd2);
      check("t2_done_cnt_1", 32'(done_cnt[1]), 32'd1);
      check("t2_done_cnt_2", 32'(done_cnt[2]), 32'd1);
      check("t2_done_cnt_3", 32'(done_cnt[3]), 32'd1);
      check("t2_outst_err",  32'(bus.outst_err), 32'd0);

      // 3. Backpressure: awrdy 1,0,0,1,1 with total 3
      set_pkt(2, 1, 2);
      bus.req = 4'b0100;
      wait_start("t3_start");
      check("t3_grant_id", 32'(bus.grant_id), 32'd2);
      tick();
      bus.axi_awvld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.axi_awrdy = pat[i];
         tick();
         check($sformatf("t3_done_%0d", i), 32'(bus.done), (i == 4) ? 32'h4 : 32'h0);
      end
      bus.req = '0;
      set_aw(1'b0);
      bdrain(3);

      // 4. Outstanding limit at MAX_OUTST=8
      set_aw(1'b1);
      repeat (7) tick();
      check("t4_hold_at_7", 32'(bus.aw_hold), 32'd0);
      tick();
      check("t4_hold_at_8", 32'(bus.aw_hold), 32'd1);
      set_aw(1'b0);
      set_b(1'b1);
      tick();
      check("t4_hold_after_b", 32'(bus.aw_hold), 32'd0);
      set_b(1'b0);
      set_aw(1'b1);
      tick();
      check("t4_hold_refill", 32'(bus.aw_hold), 32'd1);
      set_b(1'b1);
      tick();
      check("t4_hold_both", 32'(bus.aw_hold), 32'd1);
      check("t4_no_err",    32'(bus.outst_err), 32'd0);
      set_aw(1'b0);
      set_b(1'b0);
      bdrain(8);
      check("t4_drained",   32'(bus.aw_hold), 32'd0);
      check("t4_no_err2",   32'(bus.outst_err), 32'd0);

      // 5a. B handshake with nothing outstanding
      set_b(1'b1);
      tick();
      check("t5_b_err", 32'(bus.outst_err), 32'd1);
      set_b(1'b0);
      repeat (2) tick();
      check("t5_b_err_sticky", 32'(bus.outst_err), 32'd1);
      set_aw(1'b1);
      repeat (7) tick();
      check("t5_cnt_stayed0_a", 32'(bus.aw_hold), 32'd0);
      tick();
      check("t5_cnt_stayed0_b", 32'(bus.aw_hold), 32'd1);
      set_aw(1'b0);

      // 5b. AW handshake while held
      do_reset();
      check("t5_err_cleared", 32'(bus.outst_err), 32'd0);
      set_aw(1'b1);
      repeat (8) tick();
      check("t5_full_no_err", 32'(bus.outst_err), 32'd0);
      tick();
      check("t5_aw_err",      32'(bus.outst_err), 32'd1);
      check("t5_hold_kept",   32'(bus.aw_hold), 32'd1);
      set_aw(1'b0);
      set_b(1'b1);
      tick();
      check("t5_cnt_was_max", 32'(bus.aw_hold), 32'd0);
      set_b(1'b0);

      // 6. Async reset mid-XFER after 2 of 4 beats
      set_pkt(0, 2, 2);
      bus.req = 4'b0001;
      wait_start("t6_start");
      tick();
      set_aw(1'b1);
      repeat (2) tick();
      check("t6_busy_mid", 32'(bus.busy), 32'd1);
      #2;
      rstn = 1'b0;
      #1;
      check("t6_async_grant",     32'(bus.grant), 32'd0);
      check("t6_async_busy",      32'(bus.busy), 32'd0);
      check("t6_async_hdr",       32'(bus.header_flit_num), 32'd0);
      check("t6_async_dat",       32'(bus.data_flit_num), 32'd0);
      check("t6_async_aw_hold",   32'(bus.aw_hold), 32'd0);
      check("t6_async_outst_err", 32'(bus.outst_err), 32'd0);
      set_aw(1'b0);
      bus.req = '0;
      tick();
      rstn = 1'b1;
      set_pkt(1, 1, 1);
      bus.req = 4'b0010;
      tick();
      check("t6_regrant",    32'(bus.grant), 32'h2);
      check("t6_regrant_id", 32'(bus.grant_id), 32'd1);
      check("t6_restart",    32'(bus.start_aw), 32'd1);
      tick();
      set_aw(1'b1);
      tick();
      check("t6_no_done_1", 32'(bus.done), 32'd0);
      tick();
      check("t6_done",      32'(bus.done), 32'h2);
      set_aw(1'b0);
      bus.req = '0;

      // 7. Empty packet: done one cycle after XFER entry
      set_pkt(3, 0, 0);
      bus.req = 4'b1000;
      tick();
      check("t7_grant", 32'(bus.grant), 32'h8);
      check("t7_start", 32'(bus.start_aw), 32'd1);
      tick();
      check("t7_xfer_no_done", 32'(bus.done), 32'd0);
      check("t7_xfer_busy",    32'(bus.busy), 32'd1);
      tick();
      check("t7_done",         32'(bus.done), 32'h8);
      check("t7_idle",         32'(bus.busy), 32'd0);
      bus.req = '0;
      tick();
      check("t7_stay_idle",    32'(bus.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
